// File: rtl/i2c_poll_sequencer.sv
// i2c_poll_sequencer: drives an I2C master block to read a 16-bit sensor
// register, either periodically or on demand. It captures each sample,
// maintains a hysteresis alarm, and retries failed transactions before
// raising a sticky error.
//
// Handshake with the I2C master: m_start is a level request that stays high
// until the master answers with m_busy=1. While busy, the master presents
// one m_data_valid pulse with m_data, then drops m_busy. If busy falls with
// no data_valid, or a phase exceeds the watchdog, the transaction has failed.
module i2c_poll_sequencer #(
  parameter int unsigned        POLL_PERIOD    = 1000000,
  parameter int unsigned        TIMEOUT_CYCLES = 200000,
  parameter int unsigned        MAX_RETRY      = 2,
  parameter logic signed [15:0] ALARM_HI       = 16'sh1900,
  parameter logic signed [15:0] ALARM_LO       = 16'sh1800
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        trigger,
  input  logic        err_clr,
  output logic        m_start,
  input  logic        m_busy,
  input  logic [15:0] m_data,
  input  logic        m_data_valid,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        alarm,
  output logic        error,
  output logic [7:0]  fail_count,
  output logic [2:0]  seq_state
);

  localparam int unsigned PCW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_PERIOD - 1);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]     RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_RECOVER   = 3'd4
  } state_t;

  state_t         state_q;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic [WDW-1:0] wdog_q;
  logic [2:0]     retry_q;
  logic           pending_q, pending_d;
  logic           m_start_q;
  logic [15:0]    sample_q;
  logic           sample_valid_q;
  logic           alarm_q;
  logic           error_q;
  logic [7:0]     fail_count_q;

  logic poll_tick;
  logic wd_expired;
  logic launch;

  assign poll_tick  = enable && (poll_cnt_q == POLL_LAST);
  assign wd_expired = (wdog_q == WD_LAST);
  // The IDLE->START transition is what consumes a pending request.
  assign launch     = (state_q == S_IDLE) && pending_q && !m_busy;

  // Poll timer next state: free-runs while enabled, parked at 0 otherwise.
  always_comb begin
    poll_cnt_d = poll_cnt_q + 1'b1;
    if (!enable || poll_tick) poll_cnt_d = '0;
  end

  // Pending request next state: a new request beats a same-cycle launch.
  always_comb begin
    pending_d = pending_q;
    if (launch) pending_d = 1'b0;
    if (poll_tick || trigger) pending_d = 1'b1;
  end

  // Poll timer and pending request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      poll_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      pending_q  <= pending_d;
    end
  end

  // Transaction sequencer with registered outputs, watchdog and retry logic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      wdog_q         <= '0;
      retry_q        <= '0;
      m_start_q      <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      alarm_q        <= 1'b0;
      error_q        <= 1'b0;
      fail_count_q   <= '0;
    end else begin
      sample_valid_q <= 1'b0;
      // Watchdog saturates; every state that uses it clears it on entry.
      if (!wd_expired) wdog_q <= wdog_q + 1'b1;
      // A final failure later in this block overrides the clear.
      if (err_clr) error_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (launch) begin
            state_q   <= S_START;
            m_start_q <= 1'b1;
            retry_q   <= '0;
            wdog_q    <= '0;
          end
        end

        S_START: begin
          if (m_busy) begin
            state_q   <= S_WAIT_DATA;
            m_start_q <= 1'b0;
            wdog_q    <= '0;
          end else if (wd_expired) begin
            state_q   <= S_RECOVER;
            m_start_q <= 1'b0;
            wdog_q    <= '0;
          end
        end

        S_WAIT_DATA: begin
          if (m_data_valid) begin
            sample_q       <= m_data;
            sample_valid_q <= 1'b1;
            if ($signed(m_data) > ALARM_HI)      alarm_q <= 1'b1;
            else if ($signed(m_data) < ALARM_LO) alarm_q <= 1'b0;
            retry_q        <= '0;
            state_q        <= S_WAIT_IDLE;
            wdog_q         <= '0;
          end else if (!m_busy || wd_expired) begin
            state_q <= S_RECOVER;
            wdog_q  <= '0;
          end
        end

        S_WAIT_IDLE: begin
          // The sample is already captured, so a stuck busy is not a failure.
          if (!m_busy || wd_expired) state_q <= S_IDLE;
        end

        S_RECOVER: begin
          if (!m_busy || wd_expired) begin
            if (retry_q < RETRY_MAX) begin
              retry_q   <= retry_q + 1'b1;
              state_q   <= S_START;
              m_start_q <= 1'b1;
              wdog_q    <= '0;
            end else begin
              error_q <= 1'b1;
              if (fail_count_q != 8'hFF) fail_count_q <= fail_count_q + 1'b1;
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          state_q   <= S_IDLE;
          m_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_start      = m_start_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign alarm        = alarm_q;
  assign error        = error_q;
  assign fail_count   = fail_count_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Bench for i2c_poll_sequencer: a behavioural I2C master answers each start
// according to a queued response mode; a scoreboard checks every sample pulse.
module tb_i2c_poll_sequencer;

  localparam int POLL = 100;
  localparam int TMO  = 50;
  localparam int MR   = 2;

  localparam logic [1:0] M_NORMAL = 2'd0;
  localparam logic [1:0] M_NOBUSY = 2'd1;
  localparam logic [1:0] M_DROP   = 2'd2;

  // Clock / reset / DUT
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic        err_clr = 1'b0;
  logic        m_busy = 1'b0;
  logic [15:0] m_data = 16'h0;
  logic        m_data_valid = 1'b0;
  logic        m_start;
  logic [15:0] sample;
  logic        sample_valid;
  logic        alarm;
  logic        error;
  logic [7:0]  fail_count;
  logic [2:0]  seq_state;

  always #5 clk = ~clk;

  i2c_poll_sequencer #(
    .POLL_PERIOD(POLL), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR),
    .ALARM_HI(16'sh1900), .ALARM_LO(16'sh1800)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .trigger(trigger),
    .err_clr(err_clr), .m_start(m_start), .m_busy(m_busy), .m_data(m_data),
    .m_data_valid(m_data_valid), .sample(sample), .sample_valid(sample_valid),
    .alarm(alarm), .error(error), .fail_count(fail_count), .seq_state(seq_state)
  );

  // Scoreboard state
  int          n_checks = 0;
  int          n_fail = 0;
  int          sv_count = 0;
  int          start_count = 0;
  logic        start_prev = 1'b0;
  logic [15:0] exp_q[$];
  logic        exp_alarm_q[$];
  logic [15:0] mon_e;
  logic        mon_ea;

  // Slave response queues, one entry consumed per start
  logic [1:0]  mode_q[$];
  logic [15:0] data_q[$];
  logic [1:0]  md;
  logic [15:0] dd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts start requests and checks each sample pulse
  always @(negedge clk) begin
    if (m_start && !start_prev) start_count++;
    start_prev = m_start;
    if (sample_valid) begin
      sv_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got %0h expected no sample", sample);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ea = exp_alarm_q.pop_front();
        check("sample", sample, mon_e);
        check("alarm", alarm, mon_ea);
      end
    end
  end

  // Behavioural I2C master
  initial begin
    forever begin
      @(posedge clk); #1;
      if (resetn && m_start && !m_busy) begin
        if (mode_q.size() > 0) begin
          md = mode_q.pop_front();
          dd = data_q.pop_front();
        end else begin
          md = M_NORMAL;
          dd = 16'h1234;
        end
        case (md)
          M_NORMAL: begin
            repeat (2) @(posedge clk); #1 m_busy = 1'b1;
            repeat (5) @(posedge clk); #1 begin m_data = dd; m_data_valid = 1'b1; end
            @(posedge clk); #1 m_data_valid = 1'b0;
            repeat (2) @(posedge clk); #1 m_busy = 1'b0;
          end
          M_DROP: begin
            repeat (2) @(posedge clk); #1 m_busy = 1'b1;
            repeat (4) @(posedge clk); #1 m_busy = 1'b0;
          end
          default: begin
            while (m_start) begin @(posedge clk); #1; end
          end
        endcase
      end
    end
  end

  // Driver tasks
  task automatic push_txn(input logic [1:0] mode, input logic [15:0] data);
    mode_q.push_back(mode);
    data_q.push_back(data);
  endtask

  task automatic expect_sample(input logic [15:0] data, input logic a);
    exp_q.push_back(data);
    exp_alarm_q.push_back(a);
  endtask

  task automatic pulse_trigger();
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
  endtask

  task automatic wait_samples(input int target, input int budget);
    for (int i = 0; i < budget && sv_count < target; i++) @(negedge clk);
    check("sample_wait", 32'(sv_count >= target), 32'd1);
  endtask

  // Global time bound
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  int base_sv;
  int base_st;
  int cyc;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_start", m_start, 0);
    check("rst_state", seq_state, 0);
    check("rst_outputs", {sample, sample_valid, alarm, error, fail_count}, 0);

    // Periodic polling
    push_txn(M_NORMAL, 16'h1234); expect_sample(16'h1234, 1'b0);
    push_txn(M_NORMAL, 16'h1234); expect_sample(16'h1234, 1'b0);
    push_txn(M_NORMAL, 16'h1234); expect_sample(16'h1234, 1'b0);
    base_st = start_count;
    resetn = 1'b1;
    enable = 1'b1;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (m_start) break;
    end
    check("first_start_cycle", cyc, 101);
    for (int i = 0; i < 20 && !m_busy; i++) @(negedge clk);
    @(negedge clk);
    check("start_drop_on_busy", m_start, 0);
    check("state_wait_data", seq_state, 2);
    wait_samples(3, 400);
    enable = 1'b0;
    check("poll_starts", start_count - base_st, 3);
    check("poll_sample", sample, 16'h1234);

    // On-demand reads exercising alarm hysteresis
    base_sv = sv_count;
    push_txn(M_NORMAL, 16'h1A00); expect_sample(16'h1A00, 1'b1);
    pulse_trigger();
    wait_samples(base_sv + 1, 100);
    push_txn(M_NORMAL, 16'h1850); expect_sample(16'h1850, 1'b1);
    pulse_trigger();
    wait_samples(base_sv + 2, 100);
    check("alarm_hold", alarm, 1);
    push_txn(M_NORMAL, 16'h17F0); expect_sample(16'h17F0, 1'b0);
    pulse_trigger();
    wait_samples(base_sv + 3, 100);
    repeat (30) @(negedge clk);
    check("trigger_pulses", sv_count - base_sv, 3);
    check("alarm_clear", alarm, 0);

    // Master never answers: retries exhausted, sticky error
    base_sv = sv_count;
    base_st = start_count;
    push_txn(M_NOBUSY, 16'h0); push_txn(M_NOBUSY, 16'h0); push_txn(M_NOBUSY, 16'h0);
    pulse_trigger();
    for (int i = 0; i < 400 && !error; i++) @(negedge clk);
    check("error_set", error, 1);
    check("fail_count_1", fail_count, 1);
    check("idle_after_error", seq_state, 0);
    repeat (60) @(negedge clk);
    check("nobusy_starts", start_count - base_st, 3);
    check("nobusy_no_sample", sv_count - base_sv, 0);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    check("err_clr", error, 0);
    check("fail_count_kept", fail_count, 1);

    // First attempt aborts, retry succeeds
    base_st = start_count;
    push_txn(M_DROP, 16'h0);
    push_txn(M_NORMAL, 16'h0042); expect_sample(16'h0042, 1'b0);
    pulse_trigger();
    wait_samples(sv_count + 1, 300);
    repeat (10) @(negedge clk);
    check("retry_starts", start_count - base_st, 2);
    check("retry_sample", sample, 16'h0042);
    check("retry_no_error", error, 0);
    check("retry_fail_count", fail_count, 1);

    // Triggers during an active transaction collapse into one follow-up
    base_sv = sv_count;
    base_st = start_count;
    push_txn(M_NORMAL, 16'h2000); expect_sample(16'h2000, 1'b1);
    push_txn(M_NORMAL, 16'h1850); expect_sample(16'h1850, 1'b1);
    pulse_trigger();
    for (int i = 0; i < 50 && seq_state != 3'd2; i++) @(negedge clk);
    repeat (3) begin
      trigger = 1'b1;
      @(negedge clk) trigger = 1'b0;
      @(negedge clk);
    end
    repeat (120) @(negedge clk);
    check("coalesce_starts", start_count - base_st, 2);
    check("coalesce_samples", sv_count - base_sv, 2);

    // Reset while a start request is outstanding
    push_txn(M_NOBUSY, 16'h0);
    pulse_trigger();
    for (int i = 0; i < 20 && !m_start; i++) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_m_start", m_start, 0);
    check("async_state", seq_state, 0);
    check("async_outputs", {sample, sample_valid, alarm, error, fail_count}, 0);
    @(negedge clk) resetn = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_state", seq_state, 0);
    check("post_rst_outputs", {m_start, sample, sample_valid, alarm, error, fail_count}, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
